// File: rtl/frame_config_loader.sv
// Streams a header plus one data word per frame into a tile column's frame latches, strobing
// one FrameStrobe line per frame. Define FRAME_LOADER_CRC_EN to require an XOR trailer word.
module frame_config_loader #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned StrobeCycles    = 2,
  parameter logic [7:0]  SyncByte        = 8'hFA
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       err_clr
);

`ifdef FRAME_LOADER_CRC_EN
  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StStrobe, StHold, StChk} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StSetup, StStrobe, StHold} state_e;
`endif

  state_e                     state_q, state_d;
  logic [4:0]                 idx_q, idx_d;
  logic [4:0]                 rem_q, rem_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       err_set;
  logic [5:0]                 hdr_end;
  logic                       hdr_ok;
`ifdef FRAME_LOADER_CRC_EN
  logic [FrameBitsPerRow-1:0] crc_q, crc_d;
`endif

  // One past the last frame touched; 6 bits so start+cnt+1 cannot wrap.
  assign hdr_end = {1'b0, s_data[20:16]} + {1'b0, s_data[12:8]} + 6'd1;
  assign hdr_ok  = (s_data[31:24] == SyncByte) && (hdr_end <= 6'(MaxFramesPerCol));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    strobe_d = '0;
    done_d   = 1'b0;
    err_set  = 1'b0;
    s_ready  = 1'b0;
`ifdef FRAME_LOADER_CRC_EN
    crc_d    = crc_q;
`endif
    case (state_q)
      StIdle: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (hdr_ok) begin
            idx_d   = s_data[20:16];
            rem_d   = s_data[12:8];
            state_d = StLoad;
`ifdef FRAME_LOADER_CRC_EN
            crc_d   = '0;
`endif
          end else begin
            err_set = 1'b1;
          end
        end
      end
      StLoad: begin
        s_ready = 1'b1;
        if (s_valid) begin
          data_d  = s_data;
          state_d = StSetup;
`ifdef FRAME_LOADER_CRC_EN
          crc_d   = crc_q ^ s_data;
`endif
        end
      end
      StSetup: begin
        strobe_d[idx_q] = 1'b1;
        cnt_d           = 4'(StrobeCycles - 1);
        state_d         = StStrobe;
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          strobe_d = strobe_q;
        end
      end
      StHold: begin
        if (rem_q == 5'd0) begin
`ifdef FRAME_LOADER_CRC_EN
          state_d = StChk;
`else
          state_d = StIdle;
          done_d  = 1'b1;
`endif
        end else begin
          idx_d   = idx_q + 5'd1;
          rem_d   = rem_q - 5'd1;
          state_d = StLoad;
        end
      end
`ifdef FRAME_LOADER_CRC_EN
      StChk: begin
        s_ready = 1'b1;
        if (s_valid) begin
          state_d = StIdle;
          if (s_data == crc_q) done_d  = 1'b1;
          else                 err_set = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
    // A new error outranks a clear in the same cycle.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FRAME_LOADER_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef FRAME_LOADER_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;

endmodule
